updown_counter_param: RTL and testbench

Parametrised up/down counter, the successor to the fixed 4-bit up/down counter.
- Adds configurable width and modulo, count enable with prescaler, synchronous load, and a terminal-count pulse.
- Adds sticky overflow/underflow flags.
- Used as a general event/timebase counter in datapath and test designs. Single clock domain.

---
 rtl/updown_counter_param.sv | 123 ++++++++++++
 tb/tb_updown_counter_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with prescaled enable, synchronous load, terminal-count pulse
// and sticky overflow/underflow flags. Define UPDOWN_SAT_EN for saturating instead of wrapping bounds.
module updown_counter_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RST_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VALUE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // Reject parameter sets the counter cannot represent
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..32");
  end
  if (64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_counter_param: MAX_COUNT does not fit in WIDTH bits");
  end
  if (RST_VALUE > MAX_COUNT) begin : g_bad_rst
    $error("updown_counter_param: RST_VALUE exceeds MAX_COUNT");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("updown_counter_param: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] r_count;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_count_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_tc_nxt;
  logic             w_hit_max;
  logic             w_hit_min;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  // Next-state: load beats a step; a step fires on the last enabled prescaler cycle
  always_comb begin
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre_cnt;
    w_tc_nxt    = 1'b0;
    w_hit_max   = 1'b0;
    w_hit_min   = 1'b0;
    if (load) begin
      w_count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
      w_pre_nxt   = '0;
    end else if (en) begin
      if (r_pre_cnt == PRE_LAST) begin
        w_pre_nxt = '0;
        if (up) begin
          if (r_count == MAX_V) begin
            w_tc_nxt  = 1'b1;
            w_hit_max = 1'b1;
`ifdef UPDOWN_SAT_EN
            w_count_nxt = MAX_V;
`else
            w_count_nxt = '0;
`endif
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end else begin
          if (r_count == '0) begin
            w_tc_nxt  = 1'b1;
            w_hit_min = 1'b1;
`ifdef UPDOWN_SAT_EN
            w_count_nxt = '0;
`else
            w_count_nxt = MAX_V;
`endif
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end else begin
        w_pre_nxt = r_pre_cnt + PRE_W'(1);
      end
    end
    // A bound hit on the same edge as a clear leaves the flag set
    w_ovf_nxt = w_hit_max | (r_ovf & ~clr_flags);
    w_unf_nxt = w_hit_min | (r_unf & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= RST_V;
      r_pre_cnt <= '0;
      r_tc      <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_pre_cnt <= w_pre_nxt;
      r_tc      <= w_tc_nxt;
      r_ovf     <= w_ovf_nxt;
      r_unf     <= w_unf_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: PRESCALE=1 and PRESCALE=3 instances (WIDTH=4, MAX_COUNT=9),
// a behavioural model feeding per-cycle expectation queues, plus directed value checks.
module tb_updown_counter_param;

`ifdef UPDOWN_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif
  localparam int MAXC = 9;

  logic       clk;
  logic       rst, en, up, load, clr_flags;
  logic [3:0] load_val;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, ovf_a, ovf_b, unf_a, unf_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] cnt;
    logic        tc;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q_exp [2][$];

  int m_cnt [2];
  int m_pre [2];
  bit m_tc  [2];
  bit m_ovf [2];
  bit m_unf [2];
  int pres  [2] = '{1, 3};

  updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .RST_VALUE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a));

  updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .RST_VALUE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_b), .tc(tc_b), .ovf(ovf_b), .unf(unf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference for one clock edge of instance k
  task automatic model(input int k);
    exp_t e;
    if (rst) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
      m_pre[k] = 0;
      m_tc[k]  = 0;
      if (clr_flags) begin m_ovf[k] = 0; m_unf[k] = 0; end
    end else begin
      m_tc[k] = 0;
      if (clr_flags) begin m_ovf[k] = 0; m_unf[k] = 0; end
      if (en) begin
        m_pre[k] = m_pre[k] + 1;
        if (m_pre[k] == pres[k]) begin
          m_pre[k] = 0;
          if (up) begin
            if (m_cnt[k] == MAXC) begin
              m_tc[k] = 1; m_ovf[k] = 1;
              m_cnt[k] = SAT_MODE ? MAXC : 0;
            end else m_cnt[k] = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
              m_tc[k] = 1; m_unf[k] = 1;
              m_cnt[k] = SAT_MODE ? 0 : MAXC;
            end else m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
    e.cnt = 32'(m_cnt[k]); e.tc = m_tc[k]; e.ovf = m_ovf[k]; e.unf = m_unf[k];
    q_exp[k].push_back(e);
  endtask

  // Drive one cycle of inputs, clock it, then check both instances against the queue
  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lv, input logic c);
    exp_t xa, xb;
    rst = r; en = e; up = u; load = l; load_val = lv; clr_flags = c;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    xa = q_exp[0].pop_front();
    xb = q_exp[1].pop_front();
    chk("sb_a_count", 32'(cnt_a), xa.cnt);
    chk("sb_a_tc",    32'(tc_a),  32'(xa.tc));
    chk("sb_a_ovf",   32'(ovf_a), 32'(xa.ovf));
    chk("sb_a_unf",   32'(unf_a), 32'(xa.unf));
    chk("sb_b_count", 32'(cnt_b), xb.cnt);
    chk("sb_b_tc",    32'(tc_b),  32'(xb.tc));
    chk("sb_b_ovf",   32'(ovf_b), 32'(xb.ovf));
    chk("sb_b_unf",   32'(unf_b), 32'(xb.unf));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end

    // Reset state
    cyc(1, 0, 1, 0, 4'd0, 0);
    cyc(1, 1, 1, 0, 4'd0, 0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_tc",    32'(tc_a),  32'd0);
    chk("rst_flags", 32'({ovf_b, unf_b}), 32'd0);

    // Count up through MAX_COUNT
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 0, 4'd0, 0);
      chk("t1_count", 32'(cnt_a), (i == 10) ? (SAT_MODE ? 32'd9 : 32'd0) : 32'(i));
      chk("t1_tc",    32'(tc_a),  (i == 10) ? 32'd1 : 32'd0);
    end
    chk("t1_ovf", 32'(ovf_a), 32'd1);

    // Count down across zero, then clear flags
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t2_count0", 32'(cnt_a), SAT_MODE ? 32'd8 : 32'd9);
    chk("t2_tc0",    32'(tc_a),  SAT_MODE ? 32'd0 : 32'd1);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t2_count1", 32'(cnt_a), SAT_MODE ? 32'd7 : 32'd8);
    chk("t2_tc1",    32'(tc_a),  32'd0);
    chk("t2_unf",    32'(unf_a), SAT_MODE ? 32'd0 : 32'd1);
    cyc(0, 0, 0, 0, 4'd0, 1);
    chk("t2_clr", 32'({ovf_a, unf_a}), 32'd0);

    // Prescaler of 3, including a freeze mid-prescale
    cyc(1, 0, 1, 0, 4'd0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 1, 1, 0, 4'd0, 0);
      chk("t3_count", 32'(cnt_b), 32'(i / 3));
      chk("t3_tc",    32'(tc_b),  32'd0);
    end
    cyc(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 4'd0, 0);
      chk("t3_frozen", 32'(cnt_b), 32'd3);
    end
    cyc(0, 1, 1, 0, 4'd0, 0);
    chk("t3_resume0", 32'(cnt_b), 32'd3);
    cyc(0, 1, 1, 0, 4'd0, 0);
    chk("t3_resume1", 32'(cnt_b), 32'd4);

    // Load clamp, prescaler clear, reset beats load
    cyc(0, 0, 1, 1, 4'd5, 0);
    chk("t4_load5", 32'(cnt_b), 32'd5);
    cyc(0, 1, 1, 1, 4'd12, 0);
    chk("t4_clamp_a", 32'(cnt_a), 32'd9);
    chk("t4_clamp_b", 32'(cnt_b), 32'd9);
    chk("t4_tc",      32'(tc_a),  32'd0);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t4_pre0", 32'(cnt_b), 32'd9);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t4_pre1", 32'(cnt_b), 32'd9);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t4_pre2", 32'(cnt_b), 32'd8);
    cyc(1, 1, 1, 1, 4'd3, 0);
    chk("t4_rst_wins", 32'(cnt_a), 32'd0);

    // Wrap coinciding with clr_flags: set wins
    cyc(0, 0, 1, 1, 4'd9, 0);
    cyc(0, 1, 1, 0, 4'd0, 1);
    chk("t5_count", 32'(cnt_a), SAT_MODE ? 32'd9 : 32'd0);
    chk("t5_tc",    32'(tc_a),  32'd1);
    chk("t5_ovf",   32'(ovf_a), 32'd1);

    // Bound behaviour at both ends
    cyc(1, 0, 1, 0, 4'd0, 0);
    cyc(0, 0, 1, 1, 4'd8, 0);
    cyc(0, 1, 1, 0, 4'd0, 0);
    chk("t6_reach", 32'({cnt_a, tc_a}), 32'({4'd9, 1'b0}));
    cyc(0, 1, 1, 0, 4'd0, 0);
    chk("t6_blk0", 32'({cnt_a, tc_a, ovf_a}), SAT_MODE ? 32'({4'd9, 2'b11}) : 32'({4'd0, 2'b11}));
    cyc(0, 1, 1, 0, 4'd0, 0);
    chk("t6_blk1", 32'({cnt_a, tc_a}), SAT_MODE ? 32'({4'd9, 1'b1}) : 32'({4'd1, 1'b0}));
    cyc(0, 0, 0, 1, 4'd0, 0);
    cyc(0, 1, 0, 0, 4'd0, 0);
    chk("t6_low", 32'({cnt_a, tc_a, unf_a}), SAT_MODE ? 32'({4'd0, 2'b11}) : 32'({4'd9, 2'b11}));

    // Random traffic checked by the model only
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
